step_pulse_gen: RTL and testbench

Motion front-end for the stepper drive: accepts move commands (step count, direction, target rate) over a valid/ready handshake and emits single-cycle step strobes with a trapezoidal speed ramp. Each `step` strobe advances the downstream half-step phase sequencer one phase; `dir` selects the sequence direction. The block also tracks absolute position and reports completion.

---
 rtl/step_pkg.sv | 15 +
 rtl/step_ramp.sv | 60 ++++++
 rtl/step_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_step_pulse_gen.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// step_pkg: shared types and defaults for the stepper
// pulse generator and its ramp calculator.
package step_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_PER_W  = 20;
    localparam int DEF_POS_W  = 24;
    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/step_ramp.sv
// step_ramp: combinational next-period / next-ramp
// calculation applied at every step.
module step_ramp
    import step_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PER_W = DEF_PER_W
) (
    input  logic [PER_W-1:0] cur,
    input  logic [PER_W-1:0] tgt,
    input  logic [PER_W-1:0] start,
    input  logic [PER_W-1:0] cfg_accel,
    input  logic [CNT_W-1:0] rem,
    input  logic [CNT_W-1:0] ramp,
    output logic [PER_W-1:0] cur_nxt,
    output logic [CNT_W-1:0] ramp_nxt
);

    logic [PER_W:0]   sum;
    logic [PER_W-1:0] add_sat;
    logic [PER_W-1:0] sub_sat;
    logic             decel;
    logic             accel;
    logic             cruise;

    always_comb begin
        sum     = {1'b0, cur} + {1'b0, cfg_accel};
        add_sat = sum[PER_W] ? '1 : sum[PER_W-1:0];
        sub_sat = (cur > cfg_accel) ? cur - cfg_accel : '0;
    end

    // Decel has priority once remaining steps fit in the ramp.
    assign decel  = (rem <= ramp);
    assign accel  = !decel && (cur > tgt);
    assign cruise = !decel && !(cur > tgt);

    always_comb begin
        cur_nxt  = cur;
        ramp_nxt = ramp;
        unique case (1'b1)
            decel: begin
                cur_nxt  = (add_sat > start) ? start : add_sat;
                ramp_nxt = (ramp != '0) ? ramp - CNT_W'(1) : ramp;
            end
            accel: begin
                cur_nxt  = (sub_sat < tgt) ? tgt : sub_sat;
                ramp_nxt = (ramp == '1) ? ramp : ramp + CNT_W'(1);
            end
            cruise: begin
                cur_nxt  = cur;
                ramp_nxt = ramp;
            end
            default: begin
                cur_nxt  = cur;
                ramp_nxt = ramp;
            end
        endcase
    end

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: accepts move commands and emits step
// strobes with a trapezoidal speed ramp and position.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PER_W = DEF_PER_W,
    parameter int POS_W = DEF_POS_W
) (
    input  logic             clk0,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [PER_W-1:0] cfg_start_period,
    input  logic [PER_W-1:0] cfg_accel,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    state_t           state, state_n;
    logic [PER_W-1:0] timer, timer_n;
    logic [PER_W-1:0] cur, cur_n;
    logic [PER_W-1:0] tgt, tgt_n;
    logic [PER_W-1:0] start, start_n;
    logic [PER_W-1:0] accel, accel_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [CNT_W-1:0] ramp, ramp_n;
    logic [POS_W-1:0] pos_n;
    logic             dir_n;
    logic             step_n;
    logic             done_n;
    logic             busy_n;
    logic             rdy_n;

    logic [PER_W-1:0] tgt_c;
    logic [PER_W-1:0] start_c;
    logic [CNT_W-1:0] rem_dec;
    logic [PER_W-1:0] cur_r;
    logic [CNT_W-1:0] ramp_r;

    always_comb begin
        tgt_c = (cmd_period < PER_W'(MIN_PERIOD))
              ? PER_W'(MIN_PERIOD) : cmd_period;
        start_c = (cfg_start_period < tgt_c)
                ? tgt_c : cfg_start_period;
    end

    assign rem_dec = rem - CNT_W'(1);

    step_ramp #(
        .CNT_W (CNT_W),
        .PER_W (PER_W)
    ) u_ramp (
        .cur       (cur),
        .tgt       (tgt),
        .start     (start),
        .cfg_accel (accel),
        .rem       (rem_dec),
        .ramp      (ramp),
        .cur_nxt   (cur_r),
        .ramp_nxt  (ramp_r)
    );

    always_comb begin
        state_n = state;
        timer_n = timer;
        cur_n   = cur;
        tgt_n   = tgt;
        start_n = start;
        accel_n = accel;
        rem_n   = rem;
        ramp_n  = ramp;
        pos_n   = pos;
        dir_n   = dir;
        step_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    tgt_n   = tgt_c;
                    start_n = start_c;
                    cur_n   = start_c;
                    accel_n = cfg_accel;
                    rem_n   = cmd_steps;
                    ramp_n  = '0;
                    dir_n   = cmd_dir;
                    timer_n = start_c - PER_W'(1);
                    if (cmd_steps == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                // Abort beats a same-cycle expiry: no step, no move.
                if (abort || rem == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (timer == '0) begin
                    step_n  = 1'b1;
                    pos_n   = dir ? pos + POS_W'(1)
                                  : pos - POS_W'(1);
                    rem_n   = rem_dec;
                    cur_n   = cur_r;
                    ramp_n  = ramp_r;
                    timer_n = cur_r - PER_W'(1);
                end else begin
                    timer_n = timer - PER_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN);
        rdy_n  = (state_n == IDLE);
    end

    always_ff @(posedge clk0) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            cur       <= '0;
            tgt       <= '0;
            start     <= '0;
            accel     <= '0;
            rem       <= '0;
            ramp      <= '0;
            pos       <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            cur       <= cur_n;
            tgt       <= tgt_n;
            start     <= start_n;
            accel     <= accel_n;
            rem       <= rem_n;
            ramp      <= ramp_n;
            pos       <= pos_n;
            dir       <= dir_n;
            step      <= step_n;
            done      <= done_n;
            busy      <= busy_n;
            cmd_ready <= rdy_n;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed scenarios for the step
// pulse generator with hand-computed step timing.
module tb_step_pulse_gen;

    logic        clk0 = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic [19:0] cmd_period = '0;
    logic [19:0] cfg_start_period = '0;
    logic [19:0] cfg_accel = '0;
    logic        abort = 1'b0;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [23:0] pos;

    int errors = 0;
    int checks = 0;

    int st_cyc[32];
    int nst;
    int done_at;
    bit saw_busy;

    step_pulse_gen dut (
        .clk0             (clk0),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_steps        (cmd_steps),
        .cmd_dir          (cmd_dir),
        .cmd_period       (cmd_period),
        .cfg_start_period (cfg_start_period),
        .cfg_accel        (cfg_accel),
        .abort            (abort),
        .step             (step),
        .dir              (dir),
        .busy             (busy),
        .done             (done),
        .pos              (pos)
    );

    always #5 clk0 = ~clk0;

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Drive one command; the tick is the handshake edge.
    task automatic issue(input int steps, input bit d,
                         input int per, input int sp,
                         input int acc, input bit keep);
        cmd_steps = 16'(steps);
        cmd_dir = d;
        cmd_period = 20'(per);
        cfg_start_period = 20'(sp);
        cfg_accel = 20'(acc);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = keep;
    endtask

    // Cycle k = k edges after the handshake edge.
    task automatic record(input int abort_at, input int maxc);
        nst = 0;
        done_at = -1;
        saw_busy = 0;
        for (int i = 0; i < 32; i++) st_cyc[i] = -1;
        for (int k = 0; k < maxc; k++) begin
            if (step) begin
                if (nst < 32) st_cyc[nst] = k;
                nst++;
            end
            if (busy) saw_busy = 1;
            if (done) begin
                done_at = k;
                break;
            end
            abort = (k == abort_at);
            tick();
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks += 6;
        if (step !== 1'b0) begin
            errors++;
            $display("FAIL rst_step got %b want 0", step);
        end
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_done got %b want 0", done);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b want 0", busy);
        end
        if (dir !== 1'b0) begin
            errors++;
            $display("FAIL rst_dir got %b want 0", dir);
        end
        if (pos !== 24'd0) begin
            errors++;
            $display("FAIL rst_pos got %0h want 0", pos);
        end
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_rdy got %b want 0", cmd_ready);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rel_rdy got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int ex[4] = '{3, 6, 9, 12};
        issue(4, 1'b1, 3, 3, 0, 1'b0);
        record(-1, 100);
        checks++;
        if (nst !== 4) begin
            errors++;
            $display("FAIL basic_n got %0d want 4", nst);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st_cyc[i] !== ex[i]) begin
                errors++;
                $display("FAIL basic_st%0d got %0d want %0d",
                         i, st_cyc[i], ex[i]);
            end
        end
        checks += 5;
        if (done_at !== 13) begin
            errors++;
            $display("FAIL basic_done got %0d want 13", done_at);
        end
        if (pos !== 24'd4) begin
            errors++;
            $display("FAIL basic_pos got %0h want 4", pos);
        end
        if (dir !== 1'b1) begin
            errors++;
            $display("FAIL basic_dir got %b want 1", dir);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got %b want 0", busy);
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_rdy got %b want 1", cmd_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got %b want 0", done);
        end
    endtask

    task automatic test_ramp();
        int ex[6] = '{8, 13, 15, 17, 22, 30};
        issue(6, 1'b1, 2, 8, 3, 1'b0);
        record(-1, 200);
        checks++;
        if (nst !== 6) begin
            errors++;
            $display("FAIL ramp_n got %0d want 6", nst);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (st_cyc[i] !== ex[i]) begin
                errors++;
                $display("FAIL ramp_st%0d got %0d want %0d",
                         i, st_cyc[i], ex[i]);
            end
        end
        checks += 3;
        if (done_at !== 31) begin
            errors++;
            $display("FAIL ramp_done got %0d want 31", done_at);
        end
        if (pos !== 24'd10) begin
            errors++;
            $display("FAIL ramp_pos got %0h want a", pos);
        end
        if (dut.ramp !== 16'd0) begin
            errors++;
            $display("FAIL ramp_cnt got %0d want 0", dut.ramp);
        end
    endtask

    task automatic test_zero();
        issue(0, 1'b1, 5, 5, 0, 1'b0);
        record(-1, 20);
        checks += 5;
        if (done_at !== 0) begin
            errors++;
            $display("FAIL zero_done got %0d want 0", done_at);
        end
        if (nst !== 0) begin
            errors++;
            $display("FAIL zero_n got %0d want 0", nst);
        end
        if (saw_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy got %b want 0", saw_busy);
        end
        if (pos !== 24'd10) begin
            errors++;
            $display("FAIL zero_pos got %0h want a", pos);
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_rdy got %b want 1", cmd_ready);
        end
        tick();
    endtask

    task automatic test_abort();
        int extra = 0;
        apply_reset();
        issue(10, 1'b0, 3, 3, 0, 1'b0);
        record(8, 100);
        checks += 6;
        if (nst !== 2) begin
            errors++;
            $display("FAIL abort_n got %0d want 2", nst);
        end
        if (done_at !== 9) begin
            errors++;
            $display("FAIL abort_done got %0d want 9", done_at);
        end
        if (pos !== 24'hFFFFFE) begin
            errors++;
            $display("FAIL abort_pos got %0h want fffffe", pos);
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_rdy got %b want 1", cmd_ready);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b want 0", busy);
        end
        if (step !== 1'b0) begin
            errors++;
            $display("FAIL abort_step got %b want 0", step);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (step) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL abort_extra got %0d want 0", extra);
        end
    endtask

    task automatic test_clamp();
        int ex[3] = '{2, 4, 6};
        issue(3, 1'b1, 1, 1, 0, 1'b0);
        record(-1, 50);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (st_cyc[i] !== ex[i]) begin
                errors++;
                $display("FAIL clamp_st%0d got %0d want %0d",
                         i, st_cyc[i], ex[i]);
            end
        end
        checks += 2;
        if (done_at !== 7) begin
            errors++;
            $display("FAIL clamp_done got %0d want 7", done_at);
        end
        if (pos !== 24'd1) begin
            errors++;
            $display("FAIL clamp_pos got %0h want 1", pos);
        end
    endtask

    task automatic test_back_to_back();
        issue(2, 1'b1, 2, 2, 0, 1'b1);
        record(-1, 50);
        checks += 2;
        if (done_at !== 5) begin
            errors++;
            $display("FAIL b2b_done1 got %0d want 5", done_at);
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rdy1 got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy got %b want 1", busy);
        end
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rdy2 got %b want 0", cmd_ready);
        end
        record(-1, 50);
        checks += 4;
        if (st_cyc[0] !== 2 || st_cyc[1] !== 4) begin
            errors++;
            $display("FAIL b2b_st got %0d,%0d want 2,4",
                     st_cyc[0], st_cyc[1]);
        end
        if (nst !== 2) begin
            errors++;
            $display("FAIL b2b_n got %0d want 2", nst);
        end
        if (done_at !== 5) begin
            errors++;
            $display("FAIL b2b_done2 got %0d want 5", done_at);
        end
        if (pos !== 24'd5) begin
            errors++;
            $display("FAIL b2b_pos got %0h want 5", pos);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        issue(10, 1'b1, 3, 3, 0, 1'b0);
        for (int k = 0; k < 15; k++) tick();
        checks++;
        if (pos !== 24'd5) begin
            errors++;
            $display("FAIL mid_pos5 got %0h want 5", pos);
        end
        rst = 1'b0;
        cmd_steps = 16'd1;
        cmd_dir = 1'b1;
        cmd_period = 20'd2;
        cfg_start_period = 20'd2;
        cfg_accel = 20'd0;
        cmd_valid = 1'b1;
        tick();
        checks += 4;
        if (pos !== 24'd0) begin
            errors++;
            $display("FAIL mid_pos0 got %0h want 0", pos);
        end
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mid_done got %b want 0", done);
        end
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rdy0 got %b want 0", cmd_ready);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy0 got %b want 0", busy);
        end
        rst = 1'b1;
        tick();
        checks += 2;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rdy1 got %b want 1", cmd_ready);
        end
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mid_done1 got %b want 0", done);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_take got %b want 1", busy);
        end
        record(-1, 50);
        checks += 3;
        if (st_cyc[0] !== 2) begin
            errors++;
            $display("FAIL mid_st got %0d want 2", st_cyc[0]);
        end
        if (done_at !== 3) begin
            errors++;
            $display("FAIL mid_fin got %0d want 3", done_at);
        end
        if (pos !== 24'd1) begin
            errors++;
            $display("FAIL mid_pos1 got %0h want 1", pos);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp();
        test_zero();
        test_abort();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
